// File: rtl/ddsm_ncl_pipe_if.sv
// ---------------------------------------------------------------------------
// ddsm_ncl_pipe_if
// Bundle of the sample-side and result-side signals of the MASH
// noise-cancellation pipe.
//   i_en     sample strobe from the accumulator cascade
//   i_c1..3  1-bit carries of stages 1..3, already time-aligned
//   o_y      signed 4-bit NCL output
//   o_y_off  unsigned offset version of o_y (o_y + OFS)
//   o_valid  o_y/o_y_off carry a new sample this cycle
//   o_warm   differentiator history holds only real samples
// The master modport is the producer of carries (accumulator side),
// the slave modport is the NCL pipe itself.
// ---------------------------------------------------------------------------
interface ddsm_ncl_pipe_if;
  logic       i_en;
  logic       i_c1;
  logic       i_c2;
  logic       i_c3;
  logic [3:0] o_y;
  logic [2:0] o_y_off;
  logic       o_valid;
  logic       o_warm;

  modport master (
    output i_en, i_c1, i_c2, i_c3,
    input  o_y, o_y_off, o_valid, o_warm
  );

  modport slave (
    input  i_en, i_c1, i_c2, i_c3,
    output o_y, o_y_off, o_valid, o_warm
  );
endinterface

// File: rtl/ddsm_ncl_pipe.sv
// ---------------------------------------------------------------------------
// ddsm_ncl_pipe
// Pipelined MASH noise-cancellation logic:
//   y = c1 + (1 - z^-1) c2 + (1 - z^-1)^2 c3
// Stage 1 registers c1 and the two differentiated carries; stage 2 sums
// them into a signed 4-bit word and an offset unsigned word.
//
// Parameters
//   P_ORDER  modulator order 1..3; carries of higher stages are ignored
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   bus      ddsm_ncl_pipe_if.slave (carries in, y/valid/warm out)
// ---------------------------------------------------------------------------
module ddsm_ncl_pipe #(
  parameter int P_ORDER = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ddsm_ncl_pipe_if.slave        bus
);

  // Offset that maps the signed output range onto 0..2^P_ORDER-1.
  localparam logic [2:0] OFS     = (P_ORDER == 1) ? 3'd0 :
                                   (P_ORDER == 2) ? 3'd1 : 3'd3;
  localparam logic [1:0] ORD_CNT = 2'(P_ORDER);

  // Differentiator history, only shifted on accepted samples
  logic       r_c2d1;
  logic       r_c3d1;
  logic       r_c3d2;

  // Stage-1 registers
  logic       r_v1;
  logic       r_c1;
  logic [3:0] r_d2;
  logic [3:0] r_d3;

  // Warm-up tracking
  logic [1:0] r_cnt;
  logic       r_warm1;

  // Stage-2 (output) registers
  logic [3:0] r_y;
  logic [2:0] r_yOff;
  logic       r_valid;
  logic       r_warm;

  logic [3:0] w_d2;
  logic [3:0] w_d3;
  logic [1:0] w_cntNext;
  logic       w_warmHit;
  logic [3:0] w_sum;
  logic [2:0] w_yOff;

  // First and second differences of the higher-stage carries. The
  // arithmetic is done modulo 16, which yields the correct two's-complement
  // values for the small ranges involved (-1..1 and -2..2). Stages above
  // the configured order contribute nothing.
  always_comb begin
    w_d2 = 4'd0;
    w_d3 = 4'd0;
    if (P_ORDER >= 2) begin
      w_d2 = {3'b000, bus.i_c2} - {3'b000, r_c2d1};
    end
    if (P_ORDER >= 3) begin
      w_d3 = {3'b000, bus.i_c3} - {2'b00, r_c3d1, 1'b0} + {3'b000, r_c3d2};
    end
  end

  // Saturating count of accepted samples; warm is reached once the
  // sample being accepted is the P_ORDER-th one since reset.
  always_comb begin
    w_cntNext = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
    w_warmHit = (w_cntNext >= ORD_CNT);
  end

  // Stage 1: capture c1 and the differences, shift the history. Nothing
  // but the valid bit moves during an enable gap, so the differences are
  // always between consecutive accepted samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_c1    <= 1'b0;
      r_d2    <= 4'd0;
      r_d3    <= 4'd0;
      r_c2d1  <= 1'b0;
      r_c3d1  <= 1'b0;
      r_c3d2  <= 1'b0;
      r_cnt   <= 2'd0;
      r_warm1 <= 1'b0;
    end else begin
      r_v1 <= bus.i_en;
      if (bus.i_en) begin
        r_c1   <= bus.i_c1;
        r_d2   <= w_d2;
        r_d3   <= w_d3;
        r_c2d1 <= bus.i_c2;
        r_c3d1 <= bus.i_c3;
        r_c3d2 <= r_c3d1;
        r_cnt  <= w_cntNext;
        if (w_warmHit) begin
          r_warm1 <= 1'b1;
        end
      end
    end
  end

  // Stage-2 sum. The offset word is computed in 3 bits: the true value
  // always lies in 0..7, so modulo-8 addition of the low bits is exact.
  always_comb begin
    w_sum  = {3'b000, r_c1} + r_d2 + r_d3;
    w_yOff = w_sum[2:0] + OFS;
  end

  // Stage 2: register the result; outputs hold during bubbles. Warm is
  // delayed alongside the data so it rises with the matching valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y     <= 4'd0;
      r_yOff  <= 3'd0;
      r_valid <= 1'b0;
      r_warm  <= 1'b0;
    end else begin
      r_valid <= r_v1;
      r_warm  <= r_warm1;
      if (r_v1) begin
        r_y    <= w_sum;
        r_yOff <= w_yOff;
      end
    end
  end

  assign bus.o_y     = r_y;
  assign bus.o_y_off = r_yOff;
  assign bus.o_valid = r_valid;
  assign bus.o_warm  = r_warm;

endmodule

// File: tb/tb_ddsm_ncl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ddsm_ncl_pipe
// Directed bench for ddsm_ncl_pipe. Two instances share clock, reset and
// carry stimulus: u3 is built with P_ORDER=3, u1 with P_ORDER=1.
// Inputs change on the falling edge; outputs are read on the falling edge
// after the rising edge of interest. After driving sample j and waiting
// one falling edge, the outputs show sample j-1.
// ---------------------------------------------------------------------------
module tb_ddsm_ncl_pipe;

  logic clk;
  logic rst;
  logic en;
  logic c1;
  logic c2;
  logic c3;

  int total;
  int bad;

  ddsm_ncl_pipe_if bus3 ();
  ddsm_ncl_pipe_if bus1 ();

  assign bus3.i_en = en;
  assign bus3.i_c1 = c1;
  assign bus3.i_c2 = c2;
  assign bus3.i_c3 = c3;
  assign bus1.i_en = en;
  assign bus1.i_c1 = c1;
  assign bus1.i_c2 = c2;
  assign bus1.i_c3 = c3;

  ddsm_ncl_pipe #(.P_ORDER(3)) u3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  ddsm_ncl_pipe #(.P_ORDER(1)) u1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and wait for the next falling edge
  task automatic cyc(input logic e, input logic a, input logic b, input logic c);
    en = e;
    c1 = a;
    c2 = b;
    c3 = c;
    @(negedge clk);
  endtask

  // One-cycle reset with the strobe low
  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Reset with i_en high: every output and warm flag must be cleared
  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (bus3.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid3 got=%b want=0", bus3.o_valid); end
    total++; if (bus3.o_y !== 4'd0) begin bad++; $display("[TB] FAIL reset_y3 got=%h want=0", bus3.o_y); end
    total++; if (bus3.o_y_off !== 3'd0) begin bad++; $display("[TB] FAIL reset_yoff3 got=%h want=0", bus3.o_y_off); end
    total++; if (bus3.o_warm !== 1'b0) begin bad++; $display("[TB] FAIL reset_warm3 got=%b want=0", bus3.o_warm); end
    total++; if (bus1.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid1 got=%b want=0", bus1.o_valid); end
    total++; if (bus1.o_y !== 4'd0) begin bad++; $display("[TB] FAIL reset_y1 got=%h want=0", bus1.o_y); end
    total++; if (bus1.o_warm !== 1'b0) begin bad++; $display("[TB] FAIL reset_warm1 got=%b want=0", bus1.o_warm); end
    rst = 1'b0;
  endtask

  // Eight zero samples then two idle cycles
  task automatic test_steady_zero();
    logic       ev;
    logic       ew;
    logic [2:0] eo;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
      ev = (i >= 1 && i <= 8);
      ew = (i >= 3);
      eo = (i >= 1) ? 3'd3 : 3'd0;
      total++; if (bus3.o_valid !== ev) begin bad++; $display("[TB] FAIL zero_valid[%0d] got=%b want=%b", i, bus3.o_valid, ev); end
      total++; if (bus3.o_y !== 4'd0) begin bad++; $display("[TB] FAIL zero_y[%0d] got=%h want=0", i, bus3.o_y); end
      total++; if (bus3.o_y_off !== eo) begin bad++; $display("[TB] FAIL zero_yoff[%0d] got=%h want=%h", i, bus3.o_y_off, eo); end
      total++; if (bus3.o_warm !== ew) begin bad++; $display("[TB] FAIL zero_warm[%0d] got=%b want=%b", i, bus3.o_warm, ew); end
    end
  endtask

  // c3 impulse: y = +1, -2, +1, 0
  task automatic test_c3_impulse();
    logic       c3seq [4];
    logic [3:0] ey    [4];
    logic [2:0] eo    [4];
    c3seq = '{1'b1, 1'b0, 1'b0, 1'b0};
    ey    = '{4'b0001, 4'b1110, 4'b0001, 4'b0000};
    eo    = '{3'd4, 3'd1, 3'd4, 3'd3};
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, c3seq[0]);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cyc(1'b1, 1'b0, 1'b0, c3seq[i+1]);
      else       cyc(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus3.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL imp_valid[%0d] got=%b want=1", i, bus3.o_valid); end
      total++; if (bus3.o_y !== ey[i]) begin bad++; $display("[TB] FAIL imp_y[%0d] got=%h want=%h", i, bus3.o_y, ey[i]); end
      total++; if (bus3.o_y_off !== eo[i]) begin bad++; $display("[TB] FAIL imp_yoff[%0d] got=%h want=%h", i, bus3.o_y_off, eo[i]); end
    end
  endtask

  // Largest and smallest reachable outputs for order 3
  task automatic test_extremes();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_y !== 4'b0100) begin bad++; $display("[TB] FAIL max_y got=%h want=4", bus3.o_y); end
    total++; if (bus3.o_y_off !== 3'd7) begin bad++; $display("[TB] FAIL max_yoff got=%h want=7", bus3.o_y_off); end

    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_y !== 4'b0010) begin bad++; $display("[TB] FAIL mid_y got=%h want=2", bus3.o_y); end
    total++; if (bus3.o_y_off !== 3'd5) begin bad++; $display("[TB] FAIL mid_yoff got=%h want=5", bus3.o_y_off); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_y !== 4'b1101) begin bad++; $display("[TB] FAIL min_y got=%h want=d", bus3.o_y); end
    total++; if (bus3.o_y_off !== 3'd0) begin bad++; $display("[TB] FAIL min_yoff got=%h want=0", bus3.o_y_off); end
  endtask

  // Three-cycle strobe gap between c2=0 and c2=1
  task automatic test_enable_gap();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_first_valid got=%b want=1", bus3.o_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      else       cyc(1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (bus3.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL gap_valid[%0d] got=%b want=0", i, bus3.o_valid); end
      total++; if (bus3.o_y !== 4'd0) begin bad++; $display("[TB] FAIL gap_y[%0d] got=%h want=0", i, bus3.o_y); end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_after_valid got=%b want=1", bus3.o_valid); end
    total++; if (bus3.o_y !== 4'b0001) begin bad++; $display("[TB] FAIL gap_after_y got=%h want=1", bus3.o_y); end
  endtask

  // Reset while both stages hold valid data, then restart from zero history
  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    total++; if (bus3.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_pre_valid got=%b want=1", bus3.o_valid); end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (bus3.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_valid got=%b want=0", bus3.o_valid); end
    total++; if (bus3.o_y !== 4'd0) begin bad++; $display("[TB] FAIL mrst_y got=%h want=0", bus3.o_y); end
    total++; if (bus3.o_warm !== 1'b0) begin bad++; $display("[TB] FAIL mrst_warm got=%b want=0", bus3.o_warm); end
    total++; if (bus3.o_y_off !== 3'd0) begin bad++; $display("[TB] FAIL mrst_yoff got=%h want=0", bus3.o_y_off); end
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_drop_valid got=%b want=0", bus3.o_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus3.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_post_valid got=%b want=1", bus3.o_valid); end
    total++; if (bus3.o_y !== 4'd0) begin bad++; $display("[TB] FAIL mrst_post_y got=%h want=0", bus3.o_y); end
    total++; if (bus3.o_y_off !== 3'd3) begin bad++; $display("[TB] FAIL mrst_post_yoff got=%h want=3", bus3.o_y_off); end
    total++; if (bus3.o_warm !== 1'b0) begin bad++; $display("[TB] FAIL mrst_post_warm got=%b want=0", bus3.o_warm); end
  endtask

  // Order-1 instance ignores c2/c3 and is warm from its first output
  task automatic test_order1();
    logic c1seq [3];
    c1seq = '{1'b1, 1'b0, 1'b1};
    do_reset();
    cyc(1'b1, c1seq[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    total++; if (bus1.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL o1_valid_early got=%b want=0", bus1.o_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(1'b1, c1seq[i+1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else       cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++; if (bus1.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL o1_valid[%0d] got=%b want=1", i, bus1.o_valid); end
      total++; if (bus1.o_y !== {3'b000, c1seq[i]}) begin bad++; $display("[TB] FAIL o1_y[%0d] got=%h want=%h", i, bus1.o_y, c1seq[i]); end
      total++; if (bus1.o_y_off !== {2'b00, c1seq[i]}) begin bad++; $display("[TB] FAIL o1_yoff[%0d] got=%h want=%h", i, bus1.o_y_off, c1seq[i]); end
      total++; if (bus1.o_warm !== 1'b1) begin bad++; $display("[TB] FAIL o1_warm[%0d] got=%b want=1", i, bus1.o_warm); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    c1    = 1'b0;
    c2    = 1'b0;
    c3    = 1'b0;
    $display("[TB] starting ddsm_ncl_pipe directed tests");
    test_reset();
    test_steady_zero();
    test_c3_impulse();
    test_extremes();
    test_enable_gap();
    test_midstream_reset();
    test_order1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
